irq_ctrl: RTL and testbench

- Parametrised interrupt controller that replaces the fixed OR and priority-mux interrupt logic at SoC top.
- Takes N_SRC raw device interrupt lines and synchronises each one.
- Latches edge-mode events, applies a mask and priority-encodes the result, driving the registered CPU INT and CAUSE inputs.
- Exposes a Wishbone slave register file on one intercon slot so software can mask, configure and clear sources.

---
 rtl/irq_pkg.sv | 31 +++
 rtl/irq_if.sv | 12 +
 rtl/irq_sync.sv | 28 ++
 rtl/irq_ctrl.sv | 93 +++++++++
 tb/tb_irq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared register offsets, STATUS field layout and the priority encoder
// used by the interrupt controller.
package irq_pkg;

   localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
   localparam logic [1:0] IRQ_REG_MASK    = 2'd1;
   localparam logic [1:0] IRQ_REG_MODE    = 2'd2;
   localparam logic [1:0] IRQ_REG_STATUS  = 2'd3;

   // STATUS = {any_active, 26'b0, winner_index}
   localparam int STATUS_ANY_BIT = 31;
   localparam int STATUS_WIN_LSB = 0;
   localparam int STATUS_WIN_W   = 5;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
   } prio_t;

   // Lowest set bit wins; idx is 0 when nothing is set.
   function automatic prio_t prio_enc32(input logic [31:0] vec);
      prio_t r;
      r.valid = |vec;
      r.idx   = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) r.idx = 5'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/irq_if.sv
// Wishbone slave slot carrying the interrupt controller register file.
interface irq_if;
   logic        STB;
   logic        WE;
   logic [31:0] ADDR;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK;

   modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
   modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/irq_sync.sv
// Multi-stage synchroniser for raw interrupt lines, plus a one-cycle
// history of the synchronised value for edge detection.
module irq_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] prev
);
   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         prev <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1];
      end
   end

   assign s = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, level/edge pending latch,
// mask, lowest-index-first priority and a Wishbone register file.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int          N_SRC       = 8,
   parameter logic [31:0] CAUSE_BASE  = 32'h0,
   parameter logic [31:0] MODE_RST    = 32'h0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic [N_SRC-1:0] src,
   irq_if.slave             bus,
   output logic             INT,
   output logic [31:0]      CAUSE
);
   localparam logic [31:0] VALID = 32'hFFFF_FFFF >> (32 - N_SRC);

   logic [N_SRC-1:0] s_raw, prev_raw;
   logic [31:0]      s_vec, prev_vec;
   logic [31:0]      pending, mask, mode;
   logic [31:0]      act, clr, pending_nxt, rd_data, status;
   prio_t            win;
   logic             start, wr;
   logic [1:0]       reg_sel;
   logic             unused_addr;

   irq_sync #(.WIDTH(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .RSTN (RSTN),
      .d    (src),
      .s    (s_raw),
      .prev (prev_raw)
   );

   always_comb begin
      s_vec    = '0;
      prev_vec = '0;
      s_vec[N_SRC-1:0]    = s_raw;
      prev_vec[N_SRC-1:0] = prev_raw;
   end

   assign act         = pending & mask;
   assign win         = prio_enc32(act);
   assign start       = bus.STB & ~bus.ACK;
   assign wr          = start & bus.WE;
   assign reg_sel     = bus.ADDR[3:2];
   assign unused_addr = ^{bus.ADDR[31:4], bus.ADDR[1:0]};

   always_comb begin
      status = '0;
      status[STATUS_ANY_BIT] = win.valid;
      status[STATUS_WIN_LSB +: STATUS_WIN_W] = win.idx;
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         IRQ_REG_PENDING: rd_data = pending;
         IRQ_REG_MASK:    rd_data = mask;
         IRQ_REG_MODE:    rd_data = mode;
         IRQ_REG_STATUS:  rd_data = status;
         default:         rd_data = '0;
      endcase
   end

   // Clears only touch edge-mode bits; a same-cycle rising edge re-sets.
   assign clr = (wr && reg_sel == IRQ_REG_PENDING) ? (bus.DAT_I & mode & VALID) : '0;
   assign pending_nxt = ((mode & ((s_vec & ~prev_vec) | (pending & ~clr)))
                        | (~mode & s_vec)) & VALID;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         pending <= '0;
         mask    <= '0;
         mode    <= MODE_RST & VALID;
         bus.ACK <= 1'b0;
         bus.DAT_O <= '0;
         INT     <= 1'b0;
         CAUSE   <= CAUSE_BASE;
      end else begin
         pending <= pending_nxt;
         bus.ACK <= bus.STB;
         if (wr && reg_sel == IRQ_REG_MASK) mask <= bus.DAT_I & VALID;
         if (wr && reg_sel == IRQ_REG_MODE) mode <= bus.DAT_I & VALID;
         if (start && !bus.WE) bus.DAT_O <= rd_data;
         INT <= win.valid;
         if (win.valid) CAUSE <= CAUSE_BASE + 32'(win.idx);
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: default, 32-source and 4-source builds sharing one bus
// stimulus, with a cycle reference model for the default build.
module tb_irq_ctrl;
   import irq_pkg::*;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  src8;
   logic [31:0] src32;
   logic [3:0]  src4;
   logic        stb, we;
   logic [31:0] addr, dat;
   logic        int8, int32, int4;
   logic [31:0] cause8, cause32, cause4;
   logic [31:0] rd8, rd32, rd4;

   always #5 clk = ~clk;

   irq_if bus8();
   irq_if bus32();
   irq_if bus4();

   assign bus8.STB  = stb;  assign bus8.WE  = we;  assign bus8.ADDR  = addr;  assign bus8.DAT_I  = dat;
   assign bus32.STB = stb;  assign bus32.WE = we;  assign bus32.ADDR = addr;  assign bus32.DAT_I = dat;
   assign bus4.STB  = stb;  assign bus4.WE  = we;  assign bus4.ADDR  = addr;  assign bus4.DAT_I  = dat;

   irq_ctrl dut8 (.clk(clk), .RSTN(rstn), .src(src8), .bus(bus8), .INT(int8), .CAUSE(cause8));
   irq_ctrl #(.N_SRC(32), .CAUSE_BASE(32'hFFFF_FFF0)) dut32 (
      .clk(clk), .RSTN(rstn), .src(src32), .bus(bus32), .INT(int32), .CAUSE(cause32));
   irq_ctrl #(.N_SRC(4)) dut4 (
      .clk(clk), .RSTN(rstn), .src(src4), .bus(bus4), .INT(int4), .CAUSE(cause4));

   int n_assert = 0;
   int n_fail   = 0;
   bit auto_chk = 1'b0;

   // Reference state for the default build.
   logic [7:0]  m_pend, m_mask, m_mode;
   logic        m_int, m_ack;
   logic [31:0] m_cause, m_dato;
   logic [7:0]  m_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] r);
      logic [7:0] a;
      a = m_pend & m_mask;
      case (r)
         2'd0: return {24'b0, m_pend};
         2'd1: return {24'b0, m_mask};
         2'd2: return {24'b0, m_mode};
         default: return (a == 0) ? 32'h0 : 32'h8000_0000 + 32'(lowest(a));
      endcase
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_mode = '0;
      m_int = 1'b0; m_ack = 1'b0; m_cause = '0; m_dato = '0;
      m_q = {};
      for (int i = 0; i <= SYNC; i++) m_q.push_back(8'h00);
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      logic [7:0] s_old, p_old, act, rise, clr, np;
      logic [1:0] r;
      logic       start;
      logic [31:0] rd;
      s_old = m_q[SYNC-1];
      p_old = m_q[SYNC];
      act   = m_pend & m_mask;
      rise  = s_old & ~p_old;
      r     = addr[3:2];
      start = stb && !m_ack;
      rd    = m_read(r);
      clr   = (start && we && r == 2'd0) ? dat[7:0] : 8'h00;
      for (int i = 0; i < 8; i++)
         np[i] = m_mode[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : s_old[i];
      m_pend = np;
      if (start && we && r == 2'd1) m_mask = dat[7:0];
      if (start && we && r == 2'd2) m_mode = dat[7:0];
      m_int = (act != 0);
      if (act != 0) m_cause = 32'(lowest(act));
      if (start && !we) m_dato = rd;
      m_ack = stb;
      m_q.push_front(src8);
      void'(m_q.pop_back());
   endtask

   task automatic tick();
      @(posedge clk);
      if (rstn) model_step();
      #1;
      if (auto_chk) begin
         chk("model_int",   32'(int8),    32'(m_int));
         chk("model_cause", cause8,       m_cause);
         chk("model_ack",   32'(bus8.ACK), 32'(m_ack));
         chk("model_dat_o", bus8.DAT_O,   m_dato);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
      stb = 1'b1; we = 1'b1; addr = {28'h0, r, 2'b00}; dat = d;
      tick();
      stb = 1'b0; we = 1'b0;
      tick();
   endtask

   task automatic bus_read(input logic [1:0] r);
      stb = 1'b1; we = 1'b0; addr = {28'h0, r, 2'b00};
      tick();
      rd8 = bus8.DAT_O; rd32 = bus32.DAT_O; rd4 = bus4.DAT_O;
      stb = 1'b0;
      tick();
   endtask

   typedef struct {
      int          sel;
      logic [1:0]  r;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #500000;
      $display("FAIL timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int hold;
      logic [31:0] got;

      tbl[0] = '{0, IRQ_REG_MASK,    32'hFFFF_FFFF, 32'h0000_00FF};
      tbl[1] = '{1, IRQ_REG_MASK,    32'hA5A5_A5A5, 32'hA5A5_A5A5};
      tbl[2] = '{2, IRQ_REG_MASK,    32'h1234_5678, 32'h0000_0008};
      tbl[3] = '{0, IRQ_REG_MODE,    32'h0000_A5C3, 32'h0000_00C3};
      tbl[4] = '{2, IRQ_REG_MODE,    32'hFFFF_FFFF, 32'h0000_000F};
      tbl[5] = '{1, IRQ_REG_MODE,    32'h8000_0001, 32'h8000_0001};
      tbl[6] = '{0, IRQ_REG_MODE,    32'h0000_0000, 32'h0000_0000};
      tbl[7] = '{0, IRQ_REG_PENDING, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[8] = '{2, IRQ_REG_STATUS,  32'h1234_5678, 32'h0000_0000};

      // Reset with all sources high.
      rstn = 1'b1; src8 = 8'hFF; src32 = '1; src4 = 4'hF;
      stb = 1'b0; we = 1'b0; addr = '0; dat = '0;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_int",     32'(int8), 32'h0);
      chk("rst_cause",   cause8, 32'h0);
      chk("rst_ack",     32'(bus8.ACK), 32'h0);
      chk("rst_cause32", cause32, 32'hFFFF_FFF0);
      rstn = 1'b1;
      model_reset();
      auto_chk = 1'b1;
      ticks(6);
      chk("rst_int_masked", 32'(int8), 32'h0);
      bus_read(IRQ_REG_MASK);
      chk("rst_mask8",  rd8,  32'h0);
      chk("rst_mask32", rd32, 32'h0);
      src8 = '0; src32 = '0; src4 = '0;
      ticks(4);

      // Register access table.
      for (int i = 0; i < 9; i++) begin
         bus_write(tbl[i].r, tbl[i].wdata);
         bus_read(tbl[i].r);
         got = (tbl[i].sel == 0) ? rd8 : (tbl[i].sel == 1) ? rd32 : rd4;
         chk($sformatf("table_%0d", i), got, tbl[i].exp);
      end

      // Level priority.
      bus_write(IRQ_REG_MASK, 32'hFF);
      bus_write(IRQ_REG_MODE, 32'h0);
      src8 = 8'b0010_1000;
      ticks(3);
      chk("lvl_int_early", 32'(int8), 32'h0);
      tick();
      chk("lvl_int",   32'(int8), 32'h1);
      chk("lvl_cause", cause8, 32'd3);
      src8 = 8'h20;
      ticks(4);
      chk("lvl_cause5", cause8, 32'd5);
      bus_read(IRQ_REG_STATUS);
      chk("status", rd8, 32'h8000_0005);
      src8 = 8'h00;
      ticks(4);
      chk("lvl_int_off",  32'(int8), 32'h0);
      chk("lvl_cause_hold", cause8, 32'd5);

      // Edge latch and W1C.
      bus_write(IRQ_REG_MODE, 32'h01);
      bus_write(IRQ_REG_MASK, 32'h01);
      src8 = 8'h01; tick(); src8 = 8'h00;
      ticks(5);
      chk("edge_int", 32'(int8), 32'h1);
      bus_read(IRQ_REG_PENDING);
      chk("edge_pend", rd8, 32'h01);
      chk("edge_int_held", 32'(int8), 32'h1);
      bus_write(IRQ_REG_PENDING, 32'h01);
      chk("edge_int_clr", 32'(int8), 32'h0);
      bus_read(IRQ_REG_PENDING);
      chk("edge_pend_clr", rd8, 32'h00);

      // Rising edge lands in the W1C commit cycle: set wins.
      src8 = 8'h01; tick(); src8 = 8'h00;
      ticks(5);
      src8 = 8'h01;
      ticks(2);
      stb = 1'b1; we = 1'b1; addr = {28'h0, IRQ_REG_PENDING, 2'b00}; dat = 32'h01;
      tick();
      stb = 1'b0; we = 1'b0;
      tick();
      bus_read(IRQ_REG_PENDING);
      chk("collide_pend", rd8, 32'h01);
      src8 = 8'h00;
      bus_write(IRQ_REG_PENDING, 32'h01);
      ticks(3);

      // Held strobe: one commit, data change mid-strobe ignored.
      bus_write(IRQ_REG_MODE, 32'h0);
      chk("hs_ack_idle", 32'(bus8.ACK), 32'h0);
      stb = 1'b1; we = 1'b1; addr = {28'h0, IRQ_REG_MASK, 2'b00}; dat = 32'h0F;
      for (int c = 1; c <= 5; c++) begin
         if (c == 3) dat = 32'hF0;
         tick();
         chk($sformatf("hs_ack_c%0d", c + 1), 32'(bus8.ACK), 32'h1);
      end
      stb = 1'b0; we = 1'b0;
      tick();
      chk("hs_ack_fall", 32'(bus8.ACK), 32'h0);
      bus_read(IRQ_REG_MASK);
      chk("hs_mask", rd8, 32'h0F);

      // Reset in the middle of a held write.
      stb = 1'b1; we = 1'b1; addr = {28'h0, IRQ_REG_MASK, 2'b00}; dat = 32'hFF;
      tick();
      auto_chk = 1'b0;
      rstn = 1'b0;
      #1;
      chk("midrst_ack", 32'(bus8.ACK), 32'h0);
      stb = 1'b0; we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
      auto_chk = 1'b1;
      bus_read(IRQ_REG_MASK);
      chk("midrst_mask", rd8, 32'h0);

      // Parametrised builds.
      bus_write(IRQ_REG_MASK, 32'hFFFF_FFFF);
      bus_write(IRQ_REG_MODE, 32'h0);
      chk("p32_cause_rst", cause32, 32'hFFFF_FFF0);
      src32 = 32'h8000_0000; src4 = 4'b1000;
      ticks(4);
      chk("p32_int",   32'(int32), 32'h1);
      chk("p32_cause", cause32, 32'h0000_000F);
      chk("p4_int",    32'(int4), 32'h1);
      chk("p4_cause",  cause4, 32'd3);
      src32 = 32'h8000_0001;
      ticks(4);
      chk("p32_cause_win0", cause32, 32'hFFFF_FFF0);
      src32 = '0; src4 = '0;
      ticks(4);

      // Random traffic against the reference model.
      hold = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) src8 = 8'($urandom);
         if (stb) begin
            if (hold == 0) begin stb = 1'b0; we = 1'b0; end
            else hold--;
         end else if ($urandom_range(0, 3) == 0) begin
            stb = 1'b1; we = 1'($urandom); addr = $urandom; dat = $urandom;
            hold = $urandom_range(0, 2);
         end
         tick();
      end
      stb = 1'b0; we = 1'b0;
      ticks(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
